// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data RAM, memory-mapped timer and LED register; optional timer prescaler under DMEM_TIMER_PRESCALE_EN
module dmem_mmio #(
    parameter int ADDR_W = 8,
    parameter int LED_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [31:0]      aluout,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [LED_W-1:0] leds,
    output logic             irq
);

    localparam int DEPTH = 1 << ADDR_W;

    // Register word offsets (addr[7:2]) inside the MMIO window
    localparam logic [5:0] OFF_CNT   = 6'h00;
    localparam logic [5:0] OFF_CMP   = 6'h01;
    localparam logic [5:0] OFF_CTRL  = 6'h02;
    localparam logic [5:0] OFF_STAT  = 6'h03;
    localparam logic [5:0] OFF_LED   = 6'h04;
`ifdef DMEM_TIMER_PRESCALE_EN
    localparam logic [5:0] OFF_PRESC = 6'h05;
`endif

    // Address decode: low 64 KiB is RAM, top 64 KiB holds the register page
    logic              sel_ram;
    logic              sel_mmio;
    logic [5:0]        reg_off;
    logic [ADDR_W-1:0] ram_idx;
    logic              unused_addr_bits;

    assign sel_ram          = (aluout[31:16] == 16'h0000);
    assign sel_mmio         = (aluout[31:16] == 16'hFFFF) && (aluout[15:8] == 8'h00);
    assign reg_off          = aluout[7:2];
    assign ram_idx          = aluout[ADDR_W+1:2];
    assign unused_addr_bits = ^aluout[1:0];

    logic wr_cnt;
    logic wr_cmp;
    logic wr_ctrl;
    logic wr_stat;
    logic wr_led;

    assign wr_cnt  = memwrite && sel_mmio && (reg_off == OFF_CNT);
    assign wr_cmp  = memwrite && sel_mmio && (reg_off == OFF_CMP);
    assign wr_ctrl = memwrite && sel_mmio && (reg_off == OFF_CTRL);
    assign wr_stat = memwrite && sel_mmio && (reg_off == OFF_STAT);
    assign wr_led  = memwrite && sel_mmio && (reg_off == OFF_LED);

    // Architectural state
    logic [31:0]      cnt_q,   cnt_d;
    logic [31:0]      cmp_q,   cmp_d;
    logic [2:0]       ctrl_q,  ctrl_d;   // [0] en, [1] autoreload, [2] ie
    logic             match_q, match_d;
    logic [LED_W-1:0] led_q,   led_d;

    logic [31:0] ram_q [DEPTH];

    logic tick;
    logic match_hit;

`ifdef DMEM_TIMER_PRESCALE_EN
    logic [15:0] presc_q, presc_d;
    logic [15:0] pcnt_q,  pcnt_d;
    logic        wr_presc;

    assign wr_presc = memwrite && sel_mmio && (reg_off == OFF_PRESC);
    assign tick     = ctrl_q[0] && (pcnt_q == presc_q);

    // Prescale counter: restarts on any reconfiguration and idles at zero while disabled
    always_comb begin
        presc_d = presc_q;
        pcnt_d  = pcnt_q;
        if (wr_presc) begin
            presc_d = writedata[15:0];
        end
        if (wr_presc || wr_ctrl || !ctrl_q[0]) begin
            pcnt_d = 16'h0000;
        end else if (pcnt_q == presc_q) begin
            pcnt_d = 16'h0000;
        end else begin
            pcnt_d = pcnt_q + 16'h0001;
        end
    end

    // Prescaler registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= 16'h0000;
            pcnt_q  <= 16'h0000;
        end else begin
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
        end
    end
`else
    assign tick = ctrl_q[0];
`endif

    // Match is judged on the pre-write CNT and CMP so a same-cycle store never masks it
    assign match_hit = tick && (cnt_q == cmp_q);

    // Timer/LED next state: CPU store to CNT beats the tick, a new match beats W1C
    always_comb begin
        cnt_d   = cnt_q;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;
        match_d = match_q;
        led_d   = led_q;

        if (tick) begin
            if (match_hit && ctrl_q[1]) begin
                cnt_d = 32'h0000_0000;
            end else begin
                cnt_d = cnt_q + 32'h0000_0001;
            end
        end
        if (wr_cnt) begin
            cnt_d = writedata;
        end

        if (wr_cmp) begin
            cmp_d = writedata;
        end
        if (wr_ctrl) begin
            ctrl_d = writedata[2:0];
        end
        if (wr_led) begin
            led_d = writedata[LED_W-1:0];
        end

        if (wr_stat && writedata[0]) begin
            match_d = 1'b0;
        end
        if (match_hit) begin
            match_d = 1'b1;
        end
    end

    // Timer and LED registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 32'h0000_0000;
            cmp_q   <= 32'hFFFF_FFFF;
            ctrl_q  <= 3'b000;
            match_q <= 1'b0;
            led_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            match_q <= match_d;
            led_q   <= led_d;
        end
    end

    // Data RAM store port; contents are not reset
    always_ff @(posedge clk) begin
        if (memwrite && sel_ram) begin
            ram_q[ram_idx] <= writedata;
        end
    end

    // Combinational load path so a lw completes in the same cycle
    always_comb begin
        readdata = 32'h0000_0000;
        if (sel_ram) begin
            readdata = ram_q[ram_idx];
        end else if (sel_mmio) begin
            case (reg_off)
                OFF_CNT:   readdata = cnt_q;
                OFF_CMP:   readdata = cmp_q;
                OFF_CTRL:  readdata = {29'h0, ctrl_q};
                OFF_STAT:  readdata = {31'h0, match_q};
                OFF_LED:   readdata = 32'(led_q);
`ifdef DMEM_TIMER_PRESCALE_EN
                OFF_PRESC: readdata = {16'h0000, presc_q};
`endif
                default:   readdata = 32'h0000_0000;
            endcase
        end
    end

    assign leds = led_q;
    assign irq  = match_q && ctrl_q[2];

endmodule
